// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, symmetric debouncer and
// press/release pulse generator with optional auto-repeat.
module button_conditioner #(
   parameter int WIDTH            = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int SAMPLE_CNT_MAX   = 32500,
   parameter int PULSE_CNT_MAX    = 200,
   parameter int REPEAT_DELAY_CNT = 1000,
   parameter int REPEAT_RATE_CNT  = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_i,
   input  logic [WIDTH-1:0] repeat_en_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] press_o,
   output logic [WIDTH-1:0] release_o
);
   localparam int RMAX = (REPEAT_DELAY_CNT > REPEAT_RATE_CNT) ? REPEAT_DELAY_CNT : REPEAT_RATE_CNT;
   localparam int SW = $clog2(SAMPLE_CNT_MAX + 1);
   localparam int DW = $clog2(PULSE_CNT_MAX + 1);
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [SW-1:0] S_TERM  = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [DW-1:0] DB_TERM = DW'(PULSE_CNT_MAX - 1);
   localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY_CNT - 1);
   localparam logic [RW-1:0] RR_TERM = RW'(REPEAT_RATE_CNT - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [SW-1:0]    smp_q, smp_d;
   logic             tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         smp_q <= '0;
      end else begin
         sync_q[0] <= in_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         smp_q <= smp_d;
      end
   end

   assign s     = sync_q[SYNC_STAGES-1];
   assign tick  = (smp_q == S_TERM);
   assign smp_d = tick ? '0 : smp_q + 1'b1;

   for (genvar c = 0; c < WIDTH; c++) begin : g_ch
      logic [DW-1:0] db_q, db_d;
      logic [RW-1:0] rc_q, rc_d;
      logic          lvl_q, prs_q, rel_q;
      logic          flip, rise, fall, fire;
      rep_state_e    st_q, st_d;

      // the run of disagreeing ticks flips the level on its last tick
      assign flip = tick & (s[c] ^ lvl_q) & (db_q == DB_TERM);
      assign rise = flip & ~lvl_q;
      assign fall = flip & lvl_q;
      assign db_d = !tick ? db_q : (flip || s[c] == lvl_q) ? '0 : db_q + 1'b1;

      // falling level or disabled repeat wins over a same-cycle repeat pulse
      always_comb begin
         st_d = st_q;
         rc_d = rc_q;
         fire = 1'b0;
         if (fall || !repeat_en_i[c]) begin
            st_d = IDLE;
            rc_d = '0;
         end else if (st_q == IDLE) begin
            st_d = rise ? DELAY : IDLE;
            rc_d = '0;
         end else if (tick) begin
            fire = (rc_q == ((st_q == DELAY) ? RD_TERM : RR_TERM));
            rc_d = fire ? '0 : rc_q + 1'b1;
            st_d = fire ? REPEAT : st_q;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_q  <= '0;
            rc_q  <= '0;
            lvl_q <= 1'b0;
            prs_q <= 1'b0;
            rel_q <= 1'b0;
            st_q  <= IDLE;
         end else begin
            db_q  <= db_d;
            rc_q  <= rc_d;
            lvl_q <= lvl_q ^ flip;
            prs_q <= rise | fire;
            rel_q <= fall;
            st_q  <= st_d;
         end
      end

      assign level_o[c]   = lvl_q;
      assign press_o[c]   = prs_q;
      assign release_o[c] = rel_q;
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce, pulses, auto-repeat and reset
// with SAMPLE=4, PULSE=3, DELAY=5, RATE=2, SYNC=2.
module tb_button_conditioner;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in_i = '0;
   logic [3:0] repeat_en_i = '0;
   logic [3:0] level_o, press_o, release_o;
   logic [3:0] exp_l, exp_p, exp_r;
   int         checks = 0;
   int         errors = 0;
   int         cyc;

   button_conditioner #(
      .WIDTH(4), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3),
      .REPEAT_DELAY_CNT(5), .REPEAT_RATE_CNT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_i(in_i), .repeat_en_i(repeat_en_i),
      .level_o(level_o), .press_o(press_o), .release_o(release_o)
   );

   always #5 clk = ~clk;

   // cycles since reset release; ticks are processed on edges where cyc becomes a multiple of 4
   always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

   task automatic align();
      while (cyc % 4 != 0) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({level_o, press_o, release_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_in: got %b/%b/%b expected all zero", level_o, press_o, release_o);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++;
         if ({level_o, press_o, release_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_out step %0d: got %b/%b/%b expected all zero", i, level_o, press_o, release_o);
         end
      end
   endtask

   task automatic test_clean_hold();
      align();
      in_i = 4'b0001;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         exp_l = {3'b000, i >= 12 && i < 112};
         exp_p = {3'b000, i == 12};
         exp_r = {3'b000, i == 112};
         checks += 3;
         if (level_o !== exp_l) begin errors++; $display("FAIL hold_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL hold_press step %0d: got %b expected %b", i, press_o, exp_p); end
         if (release_o !== exp_r) begin errors++; $display("FAIL hold_release step %0d: got %b expected %b", i, release_o, exp_r); end
         if (i == 100) in_i = 4'b0000;
      end
   endtask

   task automatic test_bounce();
      align();
      for (int i = 0; i < 80; i++) begin
         in_i[1] = (i < 60) && ((i / 5) % 2 == 0);
         @(negedge clk);
         checks++;
         if ({level_o, press_o, release_o} !== 12'h000) begin
            errors++;
            $display("FAIL bounce step %0d: got %b/%b/%b expected all zero", i, level_o, press_o, release_o);
         end
      end
   endtask

   task automatic test_auto_repeat();
      repeat_en_i = 4'b0100;
      align();
      in_i = 4'b0100;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         exp_l = {1'b0, i >= 12 && i < 172, 2'b00};
         exp_p = {1'b0, i == 12 || (i >= 32 && i <= 168 && (i - 32) % 8 == 0), 2'b00};
         exp_r = {1'b0, i == 172, 2'b00};
         checks += 3;
         if (level_o !== exp_l) begin errors++; $display("FAIL rep_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL rep_press step %0d: got %b expected %b", i, press_o, exp_p); end
         if (release_o !== exp_r) begin errors++; $display("FAIL rep_release step %0d: got %b expected %b", i, release_o, exp_r); end
         if (i == 160) in_i = 4'b0000;
      end
   endtask

   task automatic test_release_race();
      align();
      in_i = 4'b0100;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         exp_l = {1'b0, i >= 12 && i < 168, 2'b00};
         exp_p = {1'b0, i == 12 || (i >= 32 && i < 168 && (i - 32) % 8 == 0), 2'b00};
         exp_r = {1'b0, i == 168, 2'b00};
         checks += 3;
         if (level_o !== exp_l) begin errors++; $display("FAIL race_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL race_press step %0d: got %b expected %b", i, press_o, exp_p); end
         if (release_o !== exp_r) begin errors++; $display("FAIL race_release step %0d: got %b expected %b", i, release_o, exp_r); end
         if (i == 156) in_i = 4'b0000;
      end
      repeat_en_i = 4'b0000;
   endtask

   task automatic test_reset_mid_hold();
      align();
      in_i = 4'b1000;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         exp_l = {i >= 12, 3'b000};
         exp_p = {i == 12, 3'b000};
         checks += 2;
         if (level_o !== exp_l) begin errors++; $display("FAIL pre_rst_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL pre_rst_press step %0d: got %b expected %b", i, press_o, exp_p); end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({level_o, press_o, release_o} !== 12'h000) begin
         errors++;
         $display("FAIL async_clear: got %b/%b/%b expected all zero", level_o, press_o, release_o);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         exp_l = {i >= 12 && i < 32, 3'b000};
         exp_p = {i == 12, 3'b000};
         exp_r = {i == 32, 3'b000};
         checks += 3;
         if (level_o !== exp_l) begin errors++; $display("FAIL post_rst_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL post_rst_press step %0d: got %b expected %b", i, press_o, exp_p); end
         if (release_o !== exp_r) begin errors++; $display("FAIL post_rst_release step %0d: got %b expected %b", i, release_o, exp_r); end
         if (i == 20) in_i = 4'b0000;
      end
   endtask

   task automatic test_simultaneous();
      align();
      in_i = 4'b1111;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++) begin
            exp_l[b] = i >= 12 && i < 32 + 4 * b;
            exp_r[b] = i == 32 + 4 * b;
         end
         exp_p = (i == 12) ? 4'b1111 : 4'b0000;
         checks += 3;
         if (level_o !== exp_l) begin errors++; $display("FAIL sim_level step %0d: got %b expected %b", i, level_o, exp_l); end
         if (press_o !== exp_p) begin errors++; $display("FAIL sim_press step %0d: got %b expected %b", i, press_o, exp_p); end
         if (release_o !== exp_r) begin errors++; $display("FAIL sim_release step %0d: got %b expected %b", i, release_o, exp_r); end
         if (i >= 20 && i <= 32 && i % 4 == 0) in_i[(i - 20) / 4] = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_clean_hold();
      test_bounce();
      test_auto_repeat();
      test_release_race();
      test_reset_mid_hold();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel input conditioner on `cpu_clk` for the board buttons and switches, superseding the fixed synchronizer + debouncer pair. Each of `WIDTH` channels is synchronized, debounced symmetrically on both edges, and produces a debounced level plus single-cycle press/release pulses. Each channel has optional auto-repeat, which re-issues press pulses while the button is held. The block feeds CPU reset and control logic and memory-mapped button status.

## Interface
- `WIDTH`, 4: number of independent channels.
- `SYNC_STAGES`, 2: synchronizer flop depth, ≥2.
- `SAMPLE_CNT_MAX`, 32500: clock cycles per sample tick (500 µs at 65 MHz), ≥1.
- `PULSE_CNT_MAX`, 200: consecutive disagreeing ticks needed to flip the debounced level, ≥1.
- `REPEAT_DELAY_CNT`, 1000: ticks from a debounced press to the first repeat pulse, ≥1.
- `REPEAT_RATE_CNT`, 200: ticks between subsequent repeat pulses, ≥1.
- `clk` in 1: the single clock. All state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in WIDTH: raw asynchronous inputs, active-high.
- `repeat_en` in WIDTH: per-channel auto-repeat enable, synchronous to `clk`.
- `level` out WIDTH: debounced level, registered.
- `press` out WIDTH: one-cycle pulse on each debounced press and each repeat, registered.
- `release` out WIDTH: one-cycle pulse on each debounced release, registered.

## Operation
- Synchronizer: `SYNC_STAGES` flops per bit, reset to 0. Its output is `s[i]`.
- Shared sample counter: runs 0..`SAMPLE_CNT_MAX`-1 and wraps. `tick` is high in the cycle the counter equals `SAMPLE_CNT_MAX`-1. With `SAMPLE_CNT_MAX`=1, `tick` is high every cycle.
- Debounce counter per channel, width clog2(`PULSE_CNT_MAX`+1):
  - On `tick` with `s[i]`≠`level[i]`: counter increments.
  - On `tick` with `s[i]`=`level[i]`: counter clears.
  - Between ticks: counter holds.
  - When the increment would reach `PULSE_CNT_MAX`: `level[i]` toggles and the counter clears. The counter never exceeds `PULSE_CNT_MAX`-1.
- Rising `level[i]`: `press[i]`=1 in the same cycle. Falling `level[i]`: `release[i]`=1 in the same cycle.
- Repeat FSM per channel, with states IDLE, DELAY and REPEAT. Repeat counter width is clog2(max(`REPEAT_DELAY_CNT`,`REPEAT_RATE_CNT`)+1).
  - IDLE → DELAY: on a debounced press while `repeat_en[i]`=1. The repeat counter clears.
  - DELAY: the counter increments on each `tick`. On the tick where it equals `REPEAT_DELAY_CNT`-1: emit a press pulse, clear the counter, go to REPEAT.
  - REPEAT: same behaviour, using `REPEAT_RATE_CNT`-1 as the terminal value and staying in REPEAT.
  - Any state → IDLE: when `level[i]` falls or `repeat_en[i]`=0. This takes priority over the same-cycle repeat emission.
- Channels are fully independent. Only the sample counter is shared.

## Timing
- Reset values: `level`, `press`, `release`, all counters and synchronizer flops are 0, and every FSM is in IDLE. `rst_n` low clears them asynchronously. Deassertion produces no pulses.
- Reset mid-operation:
  - A button held through reset is re-debounced from zero.
  - It yields a fresh `press` exactly `PULSE_CNT_MAX` ticks after the synchronized input is first seen by a tick.
  - Repeat restarts from IDLE.
- Debounce latency: `SYNC_STAGES` cycles to `s`, then `PULSE_CNT_MAX` ticks. Change-to-`level` latency ranges from `SYNC_STAGES`+(`PULSE_CNT_MAX`-1)·`SAMPLE_CNT_MAX`+1 to `SYNC_STAGES`+`PULSE_CNT_MAX`·`SAMPLE_CNT_MAX` cycles.
- A glitch shorter than one tick interval that is not sampled has no effect. Any tick sampling agreement resets the run.
- `press` and `release` are high for exactly one cycle per event and are never both high on one channel. A repeat never coincides with a `release`.
- Repeat pulses fall on ticks P+`REPEAT_DELAY_CNT`, then P+`REPEAT_DELAY_CNT`+k·`REPEAT_RATE_CNT` for k≥1, where P is the press tick.
- Deasserting `repeat_en[i]` suppresses further repeats from the next cycle. Re-asserting it while held does not restart repeat until the next debounced press.

## Test plan
Bench parameters: `SAMPLE_CNT_MAX`=4, `PULSE_CNT_MAX`=3, `REPEAT_DELAY_CNT`=5, `REPEAT_RATE_CNT`=2, `SYNC_STAGES`=2.

- Clean hold, ch0 (`in[0]`=1 for 100 cycles, `repeat_en`=0) -> `level[0]` rises on the 3rd tick after `s[0]`=1. Exactly one `press[0]` pulse. No other outputs change.
- Bounce, ch1 (`in[1]` toggled every 5 cycles for 60 cycles, then held 0) -> `level[1]` stays 0 and no pulses occur.
- Auto-repeat, ch2 (`repeat_en[2]`=1, `in[2]` held 40 ticks) -> press pulses at ticks P, P+5, P+7, P+9 and so on, every 2 ticks, and none after release.
- Release racing repeat (drop `in[2]` so the level falls on a tick that is also a repeat tick) -> `release[2]` only, no `press[2]`, FSM in IDLE.
- Reset mid-hold (`rst_n`=0 for 3 cycles while `level[3]`=1, `in[3]` kept 1) -> `level[3]`=0 immediately and no pulse at deassertion. New `press[3]` 3 ticks after `s[3]` is re-sampled.
- Simultaneous channels (all `in` rise in the same cycle) -> all `press` bits assert in the same cycle. Independent later releases produce per-bit `release` pulses.
